// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the digit-serial add/subtract unit: FSM states,
// mode encoding and the counter-width helper.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Bits needed to index n values; never less than one so the counter exists.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/serial_addsub_digit.sv
// Combinational DIGIT-bit add/subtract slice. Subtract is x + ~y + ~cin, with
// the carry-out inverted back into a borrow.
module addsub_digit
    import addsub_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    input  logic             mode,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             msb_cin
);

    logic             sub;
    logic [DIGIT-1:0] y_eff;
    logic [DIGIT:0]   c;

    assign sub   = (mode == MODE_SUB);
    assign y_eff = sub ? ~y : y;
    assign c[0]  = sub ? ~cin : cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign s[i]   = x[i] ^ y_eff[i] ^ c[i];
        assign c[i+1] = (x[i] & y_eff[i]) | (c[i] & (x[i] ^ y_eff[i]));
    end

    // Raw adder carry into the top bit; overflow is msb_cin ^ raw carry-out.
    assign msb_cin = c[DIGIT-1];
    assign cout    = sub ? ~c[DIGIT] : c[DIGIT];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract: DIGIT bits per clock, LSB first, with the
// carry/borrow rippled between cycles through a flop.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = clog2(N);

    if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_params
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       a_sr, b_sr;
    logic [WIDTH+DIGIT-1:0] d_cat;
    logic                   cb;
    logic                   mode_r;
    logic                   load, step, last;
    logic [DIGIT-1:0]       dig_s;
    logic                   dig_cout, dig_msb_cin, raw_cout;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x       (a_sr[DIGIT-1:0]),
        .y       (b_sr[DIGIT-1:0]),
        .cin     (cb),
        .mode    (mode_r),
        .s       (dig_s),
        .cout    (dig_cout),
        .msb_cin (dig_msb_cin)
    );

    assign last     = (cnt == CW'(N - 1));
    assign d_cat    = {dig_s, d};
    assign raw_cout = (mode_r == MODE_SUB) ? ~dig_cout : dig_cout;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no branch can infer a latch.
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state == RUN) && last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift registers are reset too, so no partial result survives a mid-run reset.
            a_sr   <= '0;
            b_sr   <= '0;
            d      <= '0;
            cb     <= 1'b0;
            mode_r <= MODE_ADD;
            cnt    <= '0;
            bo     <= 1'b0;
            ovf    <= 1'b0;
        end else if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            mode_r <= mode;
            cb     <= bi;
            cnt    <= '0;
        end else if (step) begin
            a_sr <= a_sr >> DIGIT;
            b_sr <= b_sr >> DIGIT;
            d    <= d_cat[WIDTH+DIGIT-1:DIGIT];
            cb   <= dig_cout;
            cnt  <= cnt + CW'(1);
            if (last) begin
                bo  <= dig_cout;
                ovf <= dig_msb_cin ^ raw_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench: four configurations of serial_addsub against an
// arithmetic reference model plus literal expectations from worked examples.
module tb_serial_addsub;

    localparam int NI = 4;
    localparam int W_OF [NI] = '{4, 4, 8, 8};
    localparam int N_OF [NI] = '{4, 2, 2, 8};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_v [NI];
    logic       mode_v  [NI];
    logic [7:0] a_v     [NI];
    logic [7:0] b_v     [NI];
    logic       bi_v    [NI];
    logic       busy_v  [NI];
    logic       done_v  [NI];
    logic       bo_v    [NI];
    logic       ovf_v   [NI];
    logic [7:0] d_v     [NI];
    logic [3:0] d0, d1;
    logic [7:0] d2, d3;

    assign d_v[0] = {4'h0, d0};
    assign d_v[1] = {4'h0, d1};
    assign d_v[2] = d2;
    assign d_v[3] = d3;

    serial_addsub #(.WIDTH(4), .DIGIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode_v[0]),
        .a(a_v[0][3:0]), .b(b_v[0][3:0]), .bi(bi_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .d(d0), .bo(bo_v[0]), .ovf(ovf_v[0]));
    serial_addsub #(.WIDTH(4), .DIGIT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode_v[1]),
        .a(a_v[1][3:0]), .b(b_v[1][3:0]), .bi(bi_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .d(d1), .bo(bo_v[1]), .ovf(ovf_v[1]));
    serial_addsub #(.WIDTH(8), .DIGIT(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode_v[2]),
        .a(a_v[2]), .b(b_v[2]), .bi(bi_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .d(d2), .bo(bo_v[2]), .ovf(ovf_v[2]));
    serial_addsub #(.WIDTH(8), .DIGIT(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .mode(mode_v[3]),
        .a(a_v[3]), .b(b_v[3]), .bi(bi_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .d(d3), .bo(bo_v[3]), .ovf(ovf_v[3]));

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of one operation from plain integer arithmetic: {ovf, bo, d}.
    function automatic logic [9:0] ref_op(input int w, input logic m, input logic [7:0] a,
                                          input logic [7:0] b, input logic ci);
        int mask, ua, ub, sa, sb, c, r, sr, half;
        logic rbo, rovf;
        logic [7:0] rd;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        ua   = int'(a) & mask;
        ub   = int'(b) & mask;
        c    = ci ? 1 : 0;
        sa   = (ua >= half) ? ua - (1 << w) : ua;
        sb   = (ub >= half) ? ub - (1 << w) : ub;
        if (m) begin
            r   = ua - ub - c;
            rbo = (ua < ub + c);
            sr  = sa - sb - c;
        end else begin
            r   = ua + ub + c;
            rbo = (r > mask);
            sr  = sa + sb + c;
        end
        rd   = 8'(r & mask);
        rovf = (sr < -half) || (sr > half - 1);
        return {rovf, rbo, rd};
    endfunction

    // Reference model: cycles remaining per instance and the published result.
    int         rem   [NI];
    logic [9:0] p_res [NI];
    logic       m_done[NI];
    logic [7:0] m_d   [NI];
    logic       m_bo  [NI];
    logic       m_ovf [NI];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                rem[i]    <= 0;
                m_done[i] <= 1'b0;
                m_d[i]    <= 8'h00;
                m_bo[i]   <= 1'b0;
                m_ovf[i]  <= 1'b0;
            end else if (rem[i] > 0) begin
                rem[i]    <= rem[i] - 1;
                m_done[i] <= (rem[i] == 1);
                if (rem[i] == 1) begin
                    m_d[i]   <= p_res[i][7:0];
                    m_bo[i]  <= p_res[i][8];
                    m_ovf[i] <= p_res[i][9];
                end
            end else begin
                m_done[i] <= 1'b0;
                if (start_v[i]) begin
                    rem[i]   <= N_OF[i];
                    p_res[i] <= ref_op(W_OF[i], mode_v[i], a_v[i], b_v[i], bi_v[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("u%0d busy", i), 32'(busy_v[i]), 32'(rem[i] > 0));
                check($sformatf("u%0d done", i), 32'(done_v[i]), 32'(m_done[i]));
                if (rem[i] == 0) begin
                    check($sformatf("u%0d d", i),   32'(d_v[i]),   32'(m_d[i]));
                    check($sformatf("u%0d bo", i),  32'(bo_v[i]),  32'(m_bo[i]));
                    check($sformatf("u%0d ovf", i), 32'(ovf_v[i]), 32'(m_ovf[i]));
                end
            end
        end
    end

    task automatic wait_done(input int i, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done_v[i] && cyc < 40);
        if (!done_v[i]) check($sformatf("u%0d done timeout", i), 32'd0, 32'd1);
    endtask

    // One start pulse; returns start-edge-to-done latency in cycles.
    task automatic run_op(input int i, input logic m, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, output int lat);
        int cyc;
        @(posedge clk); #1;
        start_v[i] = 1'b1; mode_v[i] = m; a_v[i] = a; b_v[i] = b; bi_v[i] = ci;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        a_v[i] = 8'($urandom);
        b_v[i] = 8'($urandom);
        mode_v[i] = 1'($urandom);
        bi_v[i] = 1'($urandom);
        wait_done(i, cyc);
        lat = cyc - 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, cyc;
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 1'b0; mode_v[i] = 1'b0; a_v[i] = 8'h00; b_v[i] = 8'h00; bi_v[i] = 1'b0;
        end
        #22 rst_n = 1'b1;
        chk_en = 1'b1;

        @(negedge clk);
        check("reset busy", 32'(busy_v[3]), 32'd0);
        check("reset done", 32'(done_v[3]), 32'd0);
        check("reset d",    32'(d_v[3]),    32'd0);
        check("reset bo",   32'(bo_v[3]),   32'd0);
        check("reset ovf",  32'(ovf_v[3]),  32'd0);

        run_op(0, 1'b1, 8'd10, 8'd4, 1'b1, lat);
        check("w4d1 10-4-1 latency", 32'(lat), 32'd4);
        check("w4d1 10-4-1 d",  32'(d_v[0]), 32'd5);
        check("w4d1 10-4-1 bo", 32'(bo_v[0]), 32'd0);

        run_op(0, 1'b1, 8'd6, 8'd8, 1'b0, lat);
        check("w4d1 6-8-0 d",  32'(d_v[0]), 32'd14);
        check("w4d1 6-8-0 bo", 32'(bo_v[0]), 32'd1);

        run_op(1, 1'b0, 8'd15, 8'd7, 1'b0, lat);
        check("w4d2 15+7 latency", 32'(lat), 32'd2);
        check("w4d2 15+7 d",   32'(d_v[1]),   32'd6);
        check("w4d2 15+7 bo",  32'(bo_v[1]),  32'd1);
        check("w4d2 15+7 ovf", 32'(ovf_v[1]), 32'd0);

        run_op(2, 1'b1, 8'h00, 8'h01, 1'b0, lat);
        check("w8d4 00-01 d",   32'(d_v[2]),   32'hFF);
        check("w8d4 00-01 bo",  32'(bo_v[2]),  32'd1);
        check("w8d4 00-01 ovf", 32'(ovf_v[2]), 32'd0);
        run_op(2, 1'b1, 8'h80, 8'h01, 1'b0, lat);
        check("w8d4 80-01 d",   32'(d_v[2]),   32'h7F);
        check("w8d4 80-01 bo",  32'(bo_v[2]),  32'd0);
        check("w8d4 80-01 ovf", 32'(ovf_v[2]), 32'd1);

        // Second start mid-run must be ignored.
        @(posedge clk); #1;
        start_v[3] = 1'b1; mode_v[3] = 1'b1; a_v[3] = 8'h35; b_v[3] = 8'h12; bi_v[3] = 1'b0;
        @(posedge clk); #1;
        start_v[3] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start_v[3] = 1'b1; mode_v[3] = 1'b0; a_v[3] = 8'hAA; b_v[3] = 8'h11; bi_v[3] = 1'b1;
        @(posedge clk); #1;
        start_v[3] = 1'b0;
        wait_done(3, cyc);
        check("mid-run start ignored d", 32'(d_v[3]), 32'h23);

        // start held across done: the next operation begins at the done edge.
        @(posedge clk); #1;
        start_v[3] = 1'b1; mode_v[3] = 1'b1; a_v[3] = 8'h50; b_v[3] = 8'h20; bi_v[3] = 1'b0;
        @(posedge clk); #1;
        mode_v[3] = 1'b0; a_v[3] = 8'h10; b_v[3] = 8'h01; bi_v[3] = 1'b1;
        wait_done(3, cyc);
        check("held start first d", 32'(d_v[3]), 32'h30);
        @(posedge clk); #1;
        check("held start no idle busy", 32'(busy_v[3]), 32'd1);
        start_v[3] = 1'b0;
        wait_done(3, cyc);
        check("held start second d", 32'(d_v[3]), 32'h12);
        check("held start second bo", 32'(bo_v[3]), 32'd0);

        // Asynchronous reset in the middle of a run.
        @(posedge clk); #1;
        start_v[3] = 1'b1; mode_v[3] = 1'b1; a_v[3] = 8'h77; b_v[3] = 8'h33; bi_v[3] = 1'b0;
        @(posedge clk); #1;
        start_v[3] = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async reset busy", 32'(busy_v[3]), 32'd0);
        check("async reset done", 32'(done_v[3]), 32'd0);
        check("async reset d",    32'(d_v[3]),    32'd0);
        check("async reset bo",   32'(bo_v[3]),   32'd0);
        check("async reset ovf",  32'(ovf_v[3]),  32'd0);
        check("async reset u0 d", 32'(d_v[0]),    32'd0);
        #8 rst_n = 1'b1;
        run_op(3, 1'b1, 8'h00, 8'h00, 1'b0, lat);
        check("after reset 0-0 latency", 32'(lat), 32'd8);
        check("after reset 0-0 d",  32'(d_v[3]),  32'd0);
        check("after reset 0-0 bo", 32'(bo_v[3]), 32'd0);

        // Randomised operations across all configurations.
        for (int k = 0; k < 40; k++) begin
            int i;
            i = int'($urandom_range(0, NI - 1));
            run_op(i, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), lat);
            check($sformatf("u%0d random latency", i), 32'(lat), 32'(N_OF[i]));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
